// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter slice.
//   - state_t   : transmitter FSM state encoding (PARITY present only when
//                 UART_PARITY_EN is defined)
//   - START_BIT / STOP_BIT / DATA_BITS : 8N1 frame constants
//   - calc_div  : clocks per line bit, CLK_FREQ/BAUD truncated
// Build option: UART_PARITY_EN adds an even-parity bit between data and stop.
package uart_pkg;

  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO feeding the UART transmitter.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push_i/wdata_i  : write a byte (ignored while full)
//   pop_i/rdata_o   : rdata_o always shows the head; pop_i advances it
//   full_o          : registered full flag
//   empty_o         : pointers equal
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic                 pop_i,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic                 full_q, full_d;
  logic                 push_ok, pop_ok;
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  assign empty_o = (wr_q == rd_q);
  assign full_o  = full_q;
  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  // Full is registered from the next-state pointers, so a pop frees the slot
  // for pushing only from the following cycle.
  always_comb begin
    wr_d   = wr_q + PW'(push_ok);
    rd_d   = rd_q + PW'(pop_ok);
    full_d = (wr_d[PW-1] != rd_d[PW-1]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      full_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_sender.sv
// uart_sender: buffered 8N1 UART transmitter.
// Parameters: CLK_FREQ (Hz), BAUD (bit/s), FIFO_DEPTH (power of two, >= 2).
// Ports:
//   clk, rst  : clock, synchronous active-high reset (aborts frame, drops queue)
//   in_data   : byte to send, sampled only on an accepted push
//   in_valid  : byte offered
//   in_ready  : registered not-full; push = in_valid & in_ready
//   tx        : serial line, idle high, registered
//   busy      : frame on the line or bytes still queued
// Build option: UART_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_sender
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned DIV      = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q;

  logic                 fifo_full, fifo_empty;
  logic                 push, pop, bit_done;
  logic [DATA_BITS-1:0] fifo_head;

  assign bit_done = (cnt_q == CNT_LAST);
  assign push     = in_valid & ~fifo_full;
  // The head is taken either from idle or at the last cycle of the stop bit,
  // giving back-to-back frames with no idle gap.
  assign pop      = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & bit_done));

  assign in_ready = ~fifo_full;
  assign tx       = tx_q;
  assign busy     = (state_q != IDLE) | ~fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (in_data),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= STOP_BIT;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          tx_q  <= STOP_BIT;
          if (pop) begin
            shift_q <= fifo_head;
            state_q <= START;
            tx_q    <= START_BIT;
          end
        end
        START: begin
          if (bit_done) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
              state_q <= PARITY;
              tx_q    <= ^shift_q;
`else
              state_q <= STOP;
              tx_q    <= STOP_BIT;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
              tx_q  <= shift_q[idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            cnt_q   <= '0;
            state_q <= STOP;
            tx_q    <= STOP_BIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (pop) begin
              shift_q <= fifo_head;
              state_q <= START;
              tx_q    <= START_BIT;
            end else begin
              state_q <= IDLE;
              tx_q    <= STOP_BIT;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          tx_q    <= STOP_BIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sender.sv
// Testbench for uart_sender (CLK_FREQ=1 MHz, BAUD=100 kbit/s, DIV=10).
// Inputs and outputs are logged once per cycle; a queue-based line model
// derived from the framing rules then predicts tx, busy and in_ready for
// every logged cycle. Directed checks cover latency, frame length and reset.
module tb_uart_sender;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned DIV      = 10;
  localparam int unsigned DEPTH    = 4;
`ifdef UART_PARITY_EN
  localparam int unsigned NBITS    = 11;
`else
  localparam int unsigned NBITS    = 10;
`endif
  localparam int unsigned FLEN     = NBITS * DIV;
  localparam int unsigned LOGN     = 16384;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;

  uart_sender #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // cyc == k between rising edge k and rising edge k+1
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // At negedge k: inputs are those applied at edge k, outputs are post-edge k.
  logic       tx_l   [LOGN];
  logic       busy_l [LOGN];
  logic       rdy_l  [LOGN];
  logic       v_l    [LOGN];
  logic       rst_l  [LOGN];
  logic [7:0] d_l    [LOGN];

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      tx_l[cyc]   = tx;
      busy_l[cyc] = busy;
      rdy_l[cyc]  = in_ready;
      v_l[cyc]    = in_valid;
      rst_l[cyc]  = rst;
      d_l[cyc]    = in_data;
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_acc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int unsigned j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef UART_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) step();
  endtask

  // Offer each byte with in_valid held until accepted; edges returns the
  // rising edge on which each byte was taken.
  task automatic send_bytes(input logic [7:0] b[$], input int unsigned max_gap,
                            output int unsigned edges[$]);
    int unsigned guard;
    edges.delete();
    foreach (b[i]) begin
      in_valid = 1'b1;
      in_data  = b[i];
      guard    = 0;
      while (!in_ready && guard < 10 * FLEN) begin
        step();
        guard++;
      end
      if (guard >= 10 * FLEN) check("ready_timeout", in_ready, 1);
      step();
      edges.push_back(cyc);
      n_acc++;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) step();
    end
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned guard = 0;
    while (busy && guard < budget) begin
      step();
      guard++;
    end
    if (guard >= budget) check(tag, busy, 0);
  endtask

  // Line model: one frame at a time, next queued byte starts the edge the
  // previous frame ends (or the edge after its push when the line is free).
  task automatic run_model(input int unsigned last);
    logic [7:0]  q[$];
    logic [7:0]  cur = '0;
    int unsigned s = 0, e = 0, acc = 0;
    logic        rdy_prev = 1'b1;
    logic        exp_tx, exp_busy, exp_rdy;
    for (int unsigned k = 1; k < last && k < LOGN; k++) begin
      if (rst_l[k]) begin
        q.delete();
        s = 0;
        e = 0;
      end else begin
        if (k >= e && q.size() > 0) begin
          cur = q.pop_front();
          s   = k;
          e   = k + FLEN;
        end
        if (v_l[k] && rdy_prev) begin
          q.push_back(d_l[k]);
          acc++;
        end
      end
      exp_tx   = (k >= s && k < e) ? frame_bit(cur, (k - s) / DIV) : 1'b1;
      exp_busy = (k < e) || (q.size() != 0);
      exp_rdy  = (q.size() < DEPTH);
      check($sformatf("tx@%0d", k), tx_l[k], exp_tx);
      check($sformatf("busy@%0d", k), busy_l[k], exp_busy);
      check($sformatf("in_ready@%0d", k), rdy_l[k], exp_rdy);
      rdy_prev = exp_rdy;
    end
    check("accept_count", n_acc, acc);
  endtask

  initial begin
    logic [7:0]  bq[$];
    int unsigned ed[$];
    int unsigned p, s;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (5) step();

    // single byte 0xA5: latency, per-bit levels, busy release
    bq = {8'hA5};
    send_bytes(bq, 0, ed);
    p = ed[0];
    check("a5_pre", tx, 1);
    step();
    check("a5_latency", tx, 0);
    for (int unsigned j = 0; j < NBITS; j++) begin
      wait_cyc(p + 1 + j * DIV + DIV / 2);
      check($sformatf("a5_bit%0d", j), tx, frame_bit(8'hA5, j));
    end
    wait_idle("a5_busy_timeout", 2 * FLEN);
    check("a5_busy_drop", cyc - (p + 1), FLEN);
    repeat (7) step();

    // back-to-back frames with no gap
    bq = {8'h00, 8'hFF, 8'h3C};
    send_bytes(bq, 0, ed);
    wait_idle("b2b_busy_timeout", 4 * FLEN);
    check("b2b_total", cyc - (ed[0] + 1), 3 * FLEN);
    repeat (4) step();

    // hold in_valid across a full FIFO
    bq = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_bytes(bq, 0, ed);
    check("full_5th_edge", ed[4], ed[0] + 4);
    check("full_6th_edge", ed[5], ed[0] + 1 + FLEN + 1);
    wait_idle("full_busy_timeout", 8 * FLEN);
    repeat (4) step();

    // reset during data bit 3 of 0x55 with two bytes queued
    bq = {8'h55, 8'h9A, 8'hC3};
    send_bytes(bq, 0, ed);
    s = ed[0] + 1;
    wait_cyc(s + 4 * DIV + 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (3 * FLEN) step();
    check("midrst_quiet", busy, 0);

`ifdef UART_PARITY_EN
    bq = {8'h07};
    send_bytes(bq, 0, ed);
    wait_cyc(ed[0] + 1 + 9 * DIV + DIV / 2);
    check("par_07", tx, 1);
    wait_idle("par_busy_timeout", 2 * FLEN);
    check("par_len", cyc - (ed[0] + 1), 110);
    bq = {8'h03};
    send_bytes(bq, 0, ed);
    wait_cyc(ed[0] + 1 + 9 * DIV + DIV / 2);
    check("par_03", tx, 0);
    wait_idle("par_busy_timeout2", 2 * FLEN);
`endif

    // random traffic: dense bursts, a random reset, then sparse bytes
    bq.delete();
    repeat (20) bq.push_back(8'($urandom));
    send_bytes(bq, 3, ed);
    repeat ($urandom_range(150, 0)) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bq.delete();
    repeat (15) bq.push_back(8'($urandom));
    send_bytes(bq, 150, ed);
    wait_idle("rand_busy_timeout", 8 * FLEN);
    repeat (20) step();

    run_model(cyc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
